red_reduce_seq: RTL and testbench

//   Parametrised, multi-cycle successor to the single-cycle RED datapath.

---
 rtl/red_reduce_seq.sv | 147 ++++++++++++++
 tb/tb_red_reduce_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_reduce_seq.sv
// red_reduce_seq: multi-cycle lane reduction unit.
// Splits two DATA_W operands into LANE_W lanes and sums all 2*N_LANES lanes,
// one lane pair per cycle, in signed or unsigned mode. The result is extended
// to DATA_W. Handshaked on both sides with valid/ready; writes no flags.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    operands and mode are valid
//   in_ready    block can accept a new operation (IDLE only)
//   a_in, b_in  operands
//   mode_signed 1: lanes are two's complement, 0: lanes are unsigned
//   out_valid   sum_out is valid (DONE only)
//   out_ready   consumer accepts the result
//   sum_out     sign/zero-extended reduction result
//   busy        operation in flight (ACCUM or DONE)
module red_reduce_seq #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              mode_signed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum_out,
    output logic              busy
);

    localparam int unsigned N_LANES = DATA_W / LANE_W;
    // Enough headroom for 2*N_LANES lanes, so the accumulator never overflows.
    localparam int unsigned SUM_W   = LANE_W + $clog2(2 * N_LANES);
    localparam int unsigned IDX_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    if (LANE_W == 0 || N_LANES == 0 || (DATA_W % LANE_W) != 0) begin : g_bad_lanes
        $error("red_reduce_seq: DATA_W must be a non-zero multiple of LANE_W");
    end
    if (SUM_W > DATA_W) begin : g_bad_sum_w
        $error("red_reduce_seq: SUM_W exceeds DATA_W");
    end

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic               sgn_q, sgn_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SUM_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]  sum_q, sum_d;

    logic [LANE_W-1:0]  lane_a, lane_b;
    logic               last_lane;

    // Fill the upper bits first, then overlay the value; avoids a
    // zero-count replication when the extension width happens to be 0.
    function automatic logic [SUM_W-1:0] ext_lane(input logic [LANE_W-1:0] lane,
                                                  input logic sgn);
        logic [SUM_W-1:0] r;
        r = {SUM_W{sgn & lane[LANE_W-1]}};
        r[LANE_W-1:0] = lane;
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] ext_sum(input logic [SUM_W-1:0] acc,
                                                  input logic sgn);
        logic [DATA_W-1:0] r;
        r = {DATA_W{sgn & acc[SUM_W-1]}};
        r[SUM_W-1:0] = acc;
        return r;
    endfunction

    assign lane_a    = a_q[32'(idx_q) * LANE_W +: LANE_W];
    assign lane_b    = b_q[32'(idx_q) * LANE_W +: LANE_W];
    assign last_lane = (idx_q == IDX_W'(N_LANES - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    sgn_d   = mode_signed;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                acc_d = acc_q + ext_lane(lane_a, sgn_q) + ext_lane(lane_b, sgn_q);
                idx_d = idx_q + IDX_W'(1);
                if (last_lane) begin
                    idx_d   = '0;
                    sum_d   = ext_sum(acc_d, sgn_q);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StAccum) || (state_q == StDone);
    assign sum_out   = sum_q;

endmodule

// File: tb/tb_red_reduce_seq.sv
module tb_red_reduce_seq;

    localparam int DW  = 16;
    localparam int LW  = 8;
    localparam int NL  = DW / LW;
    localparam int WDW = 32;
    localparam int WNL = WDW / LW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default-width instance
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a_in = '0;
    logic [DW-1:0] b_in = '0;
    logic          mode_signed = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] sum_out;
    logic          busy;

    // Wide instance
    logic           w_in_valid = 1'b0;
    logic           w_in_ready;
    logic [WDW-1:0] w_a = '0;
    logic [WDW-1:0] w_b = '0;
    logic           w_sgn = 1'b0;
    logic           w_out_valid;
    logic           w_out_ready = 1'b0;
    logic [WDW-1:0] w_sum;
    logic           w_busy;

    int n_checks = 0;
    int n_errors = 0;

    red_reduce_seq #(.DATA_W(DW), .LANE_W(LW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .mode_signed(mode_signed),
        .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out), .busy(busy)
    );

    red_reduce_seq #(.DATA_W(WDW), .LANE_W(LW)) dut_w (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a_in(w_a), .b_in(w_b), .mode_signed(w_sgn),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .sum_out(w_sum), .busy(w_busy)
    );

    // Reference: integer sum of all lanes, truncated to the result width.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input bit sgn, input int dw, input int lw);
        int sum;
        int la;
        int lb;
        sum = 0;
        for (int i = 0; i < dw / lw; i++) begin
            la = int'((a >> (i * lw)) & ((32'd1 << lw) - 1));
            lb = int'((b >> (i * lw)) & ((32'd1 << lw) - 1));
            if (sgn && la >= (1 << (lw - 1))) la -= (1 << lw);
            if (sgn && lb >= (1 << (lw - 1))) lb -= (1 << lw);
            sum += la + lb;
        end
        return 32'(sum);
    endfunction

    // One full operation on the default instance; called and returning at a negedge.
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit sgn,
                          input int hold, input string name);
        logic [DW-1:0] exp;
        int cnt;
        exp = model(32'(a), 32'(b), sgn, DW, LW)[DW-1:0];
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s ready_before: in_ready=%b want 1", name, in_ready);
        end
        in_valid = 1'b1; a_in = a; b_in = b; mode_signed = sgn;
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 20) begin
            // Operand/valid noise while accumulating must not matter.
            a_in = DW'($urandom); b_in = DW'($urandom);
            mode_signed = 1'($urandom); in_valid = 1'($urandom);
            @(negedge clk);
            cnt++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (cnt != NL) begin
            n_errors++;
            $display("FAIL %s latency: got %0d edges want %0d", name, cnt, NL);
        end
        repeat (hold) @(negedge clk);
        n_checks++;
        if (sum_out !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL %s result: sum=%h ov=%b ir=%b want sum=%h ov=1 ir=0",
                     name, sum_out, out_valid, in_ready, exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || sum_out !== exp) begin
            n_errors++;
            $display("FAIL %s release: ov=%b ir=%b busy=%b sum=%h want 0 1 0 %h",
                     name, out_valid, in_ready, busy, sum_out, exp);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum_out !== '0 ||
            w_in_ready !== 1'b1 || w_out_valid !== 1'b0 || w_sum !== '0) begin
            n_errors++;
            $display("FAIL reset: ir=%b ov=%b busy=%b sum=%h wsum=%h want 1 0 0 0 0",
                     in_ready, out_valid, busy, sum_out, w_sum);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 0, "ffff_unsigned");
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, "ffff_signed");
        run_op(16'h7F7F, 16'h7F7F, 1'b1, 1, "7f7f_signed");
        run_op(16'h8080, 16'h8080, 1'b1, 0, "8080_signed");
        run_op(16'h8080, 16'h8080, 1'b0, 0, "8080_unsigned");
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp;
        exp = 16'h01FC;
        in_valid = 1'b1; a_in = 16'h7F7F; b_in = 16'h7F7F; mode_signed = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (NL) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum_out !== exp || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL backpressure cyc%0d: ov=%b ir=%b busy=%b sum=%h want 1 0 1 %h",
                         i, out_valid, in_ready, busy, sum_out, exp);
            end
            in_valid = (i == 2); a_in = 16'h1111; b_in = 16'h2222;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || sum_out !== exp) begin
            n_errors++;
            $display("FAIL backpressure release: ov=%b ir=%b busy=%b sum=%h want 0 1 0 %h",
                     out_valid, in_ready, busy, sum_out, exp);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; a_in = 16'hFFFF; b_in = 16'hFFFF; mode_signed = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum_out !== '0) begin
            n_errors++;
            $display("FAIL reset_mid: ir=%b ov=%b busy=%b sum=%h want 1 0 0 0",
                     in_ready, out_valid, busy, sum_out);
        end
        run_op(16'h0102, 16'h0304, 1'b0, 0, "after_reset");
        n_checks++;
        if (sum_out !== 16'h000A) begin
            n_errors++;
            $display("FAIL after_reset_const: sum=%h want 000a", sum_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(DW'($urandom), DW'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                   "random");
        end
    endtask

    // out_ready tied high, in_valid always high: one op every NL+2 cycles.
    task automatic test_back_to_back();
        logic [DW-1:0] q[$];
        int last_acc;
        int n_acc;
        logic [DW-1:0] exp;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a_in = DW'($urandom); b_in = DW'($urandom); mode_signed = 1'($urandom);
        last_acc = -1;
        n_acc = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (out_valid === 1'b1) begin
                exp = (q.size() > 0) ? q.pop_front() : 'x;
                n_checks++;
                if (sum_out !== exp) begin
                    n_errors++;
                    $display("FAIL b2b result: sum=%h want %h", sum_out, exp);
                end
            end
            if (in_ready === 1'b1) begin
                q.push_back(model(32'(a_in), 32'(b_in), mode_signed, DW, LW)[DW-1:0]);
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc != NL + 2) begin
                        n_errors++;
                        $display("FAIL b2b spacing: got %0d want %0d", cyc - last_acc, NL + 2);
                    end
                end
                last_acc = cyc;
                n_acc++;
            end
            @(negedge clk);
            if (in_ready === 1'b0 && busy === 1'b1 && out_valid === 1'b0) begin
                a_in = DW'($urandom); b_in = DW'($urandom); mode_signed = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (n_acc < 10) begin
            n_errors++;
            $display("FAIL b2b accepts: got %0d want >= 10", n_acc);
        end
        repeat (NL + 3) @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_wide();
        logic [WDW-1:0] a;
        logic [WDW-1:0] b;
        logic [WDW-1:0] exp;
        bit sgn;
        int cnt;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                a = 32'h01020304; b = 32'h01020304; sgn = 1'b0;
            end else begin
                a = $urandom; b = $urandom; sgn = 1'($urandom);
            end
            exp = model(a, b, sgn, WDW, LW);
            if (i == 0) exp = 32'h00000014;
            w_in_valid = 1'b1; w_a = a; w_b = b; w_sgn = sgn;
            @(negedge clk);
            w_in_valid = 1'b0;
            w_a = $urandom;
            cnt = 0;
            while (w_out_valid !== 1'b1 && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            n_checks++;
            if (cnt != WNL || w_sum !== exp) begin
                n_errors++;
                $display("FAIL wide op%0d: latency=%0d sum=%h want %0d %h",
                         i, cnt, w_sum, WNL, exp);
            end
            w_out_ready = 1'b1;
            @(negedge clk);
            w_out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
